// File: rtl/ulpi_phy_emu.sv
// rtl/ulpi_phy_emu.sv - ULPI PHY emulator with register file, RXCMD reporting and startup sequencing
module ulpi_phy_emu #(
    parameter logic [15:0] VENDOR_ID   = 16'h0424,
    parameter logic [15:0] PRODUCT_ID  = 16'h0006,
    parameter int          STARTUP_CYC = 4,
    parameter int          WR_TIMEOUT  = 16
) (
    input  logic       CLK_60M,
    input  logic       NRST_A_USB,
    input  logic [7:0] ULPI_DATA_I,
    output logic [7:0] ULPI_DATA_O,
    output logic       ULPI_DATA_OE,
    output logic       ULPI_DIR,
    output logic       ULPI_NXT,
    input  logic       ULPI_STP,
    input  logic       ULPI_RESETN,
    input  logic [1:0] LINESTATE,
    input  logic [1:0] VBUS_STATE,
    output logic [7:0] FUNC_CTRL,
    output logic       REG_WR_PULSE
);

    localparam logic [3:0] ST_TA    = 4'd0;
    localparam logic [3:0] ST_RXCMD = 4'd1;
    localparam logic [3:0] IDLE     = 4'd2;
    localparam logic [3:0] WR_NXT   = 4'd3;
    localparam logic [3:0] WR_DATA  = 4'd4;
    localparam logic [3:0] RD_NXT   = 4'd5;
    localparam logic [3:0] RD_TA    = 4'd6;
    localparam logic [3:0] RD_DATA  = 4'd7;
    localparam logic [3:0] RX_TA    = 4'd8;
    localparam logic [3:0] RX_DATA  = 4'd9;

    localparam int SCW = $clog2(STARTUP_CYC + 1);
    localparam int WCW = $clog2(WR_TIMEOUT + 1);

    localparam logic [7:0] FUNC_RST = 8'h41;
    localparam logic [7:0] INTF_RST = 8'h00;
    localparam logic [7:0] OTG_RST  = 8'h06;
    localparam logic [7:0] SCR_RST  = 8'h00;

    logic [3:0]     state;
    logic [SCW-1:0] st_cnt;
    logic [WCW-1:0] wr_cnt;
    logic [5:0]     addr;
    logic [7:0]     wr_buf;
    logic [7:0]     last_rxcmd;
    logic [7:0]     func_ctrl, intf_ctrl, otg_ctrl, scratch;
    logic [7:0]     func_nxt, intf_nxt, otg_nxt, scratch_nxt;
    logic [7:0]     rxcmd;
    logic [7:0]     rd_val;
    logic           commit;

    assign rxcmd     = {4'b0000, VBUS_STATE, LINESTATE};
    // A commit needs at least one captured data byte before STP.
    assign commit    = (state == WR_DATA) && ULPI_STP && (wr_cnt != '0);
    assign FUNC_CTRL = func_ctrl;

    always_comb begin
        rd_val = 8'h00;
        case (addr)
            6'h00:                rd_val = VENDOR_ID[7:0];
            6'h01:                rd_val = VENDOR_ID[15:8];
            6'h02:                rd_val = PRODUCT_ID[7:0];
            6'h03:                rd_val = PRODUCT_ID[15:8];
            6'h04, 6'h05, 6'h06:  rd_val = func_ctrl;
            6'h07, 6'h08, 6'h09:  rd_val = intf_ctrl;
            6'h0A, 6'h0B, 6'h0C:  rd_val = otg_ctrl;
            6'h16, 6'h17, 6'h18:  rd_val = scratch;
            default:              rd_val = 8'h00;
        endcase
    end

    // Function Control bit 5 (Reset) never survives more than one cycle.
    always_comb begin
        func_nxt    = func_ctrl & 8'hDF;
        intf_nxt    = intf_ctrl;
        otg_nxt     = otg_ctrl;
        scratch_nxt = scratch;
        if (commit) begin
            case (addr)
                6'h04:   func_nxt    = wr_buf;
                6'h05:   func_nxt    = func_nxt | wr_buf;
                6'h06:   func_nxt    = func_nxt & ~wr_buf;
                6'h07:   intf_nxt    = wr_buf;
                6'h08:   intf_nxt    = intf_ctrl | wr_buf;
                6'h09:   intf_nxt    = intf_ctrl & ~wr_buf;
                6'h0A:   otg_nxt     = wr_buf;
                6'h0B:   otg_nxt     = otg_ctrl | wr_buf;
                6'h0C:   otg_nxt     = otg_ctrl & ~wr_buf;
                6'h16:   scratch_nxt = wr_buf;
                6'h17:   scratch_nxt = scratch | wr_buf;
                6'h18:   scratch_nxt = scratch & ~wr_buf;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
        if (!NRST_A_USB) begin
            func_ctrl    <= FUNC_RST;
            intf_ctrl    <= INTF_RST;
            otg_ctrl     <= OTG_RST;
            scratch      <= SCR_RST;
            REG_WR_PULSE <= 1'b0;
        end else if (!ULPI_RESETN) begin
            func_ctrl    <= FUNC_RST;
            intf_ctrl    <= INTF_RST;
            otg_ctrl     <= OTG_RST;
            scratch      <= SCR_RST;
            REG_WR_PULSE <= 1'b0;
        end else begin
            func_ctrl    <= func_nxt;
            intf_ctrl    <= intf_nxt;
            otg_ctrl     <= otg_nxt;
            scratch      <= scratch_nxt;
            REG_WR_PULSE <= commit;
        end
    end

    always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
        if (!NRST_A_USB) begin
            state      <= ST_TA;
            st_cnt     <= '0;
            wr_cnt     <= '0;
            addr       <= '0;
            wr_buf     <= 8'h00;
            last_rxcmd <= 8'h00;
        end else if (!ULPI_RESETN) begin
            state      <= ST_TA;
            st_cnt     <= '0;
            wr_cnt     <= '0;
            addr       <= '0;
            wr_buf     <= 8'h00;
            last_rxcmd <= 8'h00;
        end else begin
            case (state)
                ST_TA: begin
                    state  <= ST_RXCMD;
                    st_cnt <= '0;
                end
                ST_RXCMD: begin
                    if (st_cnt == SCW'(STARTUP_CYC - 1)) state <= IDLE;
                    else                                 st_cnt <= st_cnt + 1'b1;
                end
                // TXCMD decode wins; a pending RXCMD waits for a quiet bus.
                IDLE: begin
                    if (ULPI_DATA_I[7:6] == 2'b10) begin
                        state <= WR_NXT;
                        addr  <= ULPI_DATA_I[5:0];
                    end else if (ULPI_DATA_I[7:6] == 2'b11) begin
                        state <= RD_NXT;
                        addr  <= ULPI_DATA_I[5:0];
                    end else if (ULPI_DATA_I == 8'h00 && rxcmd != last_rxcmd) begin
                        state <= RX_TA;
                    end
                end
                WR_NXT: begin
                    state  <= WR_DATA;
                    wr_cnt <= '0;
                end
                WR_DATA: begin
                    if (ULPI_STP) begin
                        state <= IDLE;
                    end else begin
                        wr_buf <= ULPI_DATA_I;
                        if (wr_cnt == WCW'(WR_TIMEOUT - 1)) state <= IDLE;
                        else                                wr_cnt <= wr_cnt + 1'b1;
                    end
                end
                RD_NXT:  state <= RD_TA;
                RD_TA:   state <= RD_DATA;
                RD_DATA: state <= IDLE;
                RX_TA:   state <= RX_DATA;
                RX_DATA: begin
                    last_rxcmd <= rxcmd;
                    state      <= IDLE;
                end
                default: state <= ST_TA;
            endcase
        end
    end

    always_comb begin
        ULPI_DIR     = 1'b0;
        ULPI_DATA_OE = 1'b0;
        ULPI_NXT     = 1'b0;
        ULPI_DATA_O  = 8'h00;
        case (state)
            ST_TA, RD_TA, RX_TA: ULPI_DIR = 1'b1;
            ST_RXCMD, RX_DATA: begin
                ULPI_DIR     = 1'b1;
                ULPI_DATA_OE = 1'b1;
                ULPI_DATA_O  = rxcmd;
            end
            RD_DATA: begin
                ULPI_DIR     = 1'b1;
                ULPI_DATA_OE = 1'b1;
                ULPI_DATA_O  = rd_val;
            end
            WR_NXT, RD_NXT: ULPI_NXT = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ulpi_phy_emu.sv
// tb/tb_ulpi_phy_emu.sv - self-checking bench for ulpi_phy_emu
module tb_ulpi_phy_emu;

    localparam logic [15:0] VID         = 16'h0424;
    localparam logic [15:0] PID         = 16'h0006;
    localparam int          STARTUP_CYC = 4;
    localparam int          WR_TIMEOUT  = 16;

    logic       CLK_60M = 1'b0;
    logic       NRST_A_USB;
    logic [7:0] ULPI_DATA_I;
    logic [7:0] ULPI_DATA_O;
    logic       ULPI_DATA_OE;
    logic       ULPI_DIR;
    logic       ULPI_NXT;
    logic       ULPI_STP;
    logic       ULPI_RESETN;
    logic [1:0] LINESTATE;
    logic [1:0] VBUS_STATE;
    logic [7:0] FUNC_CTRL;
    logic       REG_WR_PULSE;

    int checks   = 0;
    int failures = 0;

    logic       check_en = 1'b0;
    logic       e_dir, e_oe, e_nxt, e_pulse;
    logic [7:0] e_dat, e_func;

    // Model: Function, Interface, OTG, Scratch base registers, plus last reported RXCMD.
    logic [7:0] m_reg [4];
    logic [7:0] m_last;

    ulpi_phy_emu #(
        .VENDOR_ID   (VID),
        .PRODUCT_ID  (PID),
        .STARTUP_CYC (STARTUP_CYC),
        .WR_TIMEOUT  (WR_TIMEOUT)
    ) dut (
        .CLK_60M      (CLK_60M),
        .NRST_A_USB   (NRST_A_USB),
        .ULPI_DATA_I  (ULPI_DATA_I),
        .ULPI_DATA_O  (ULPI_DATA_O),
        .ULPI_DATA_OE (ULPI_DATA_OE),
        .ULPI_DIR     (ULPI_DIR),
        .ULPI_NXT     (ULPI_NXT),
        .ULPI_STP     (ULPI_STP),
        .ULPI_RESETN  (ULPI_RESETN),
        .LINESTATE    (LINESTATE),
        .VBUS_STATE   (VBUS_STATE),
        .FUNC_CTRL    (FUNC_CTRL),
        .REG_WR_PULSE (REG_WR_PULSE)
    );

    always #8 CLK_60M = ~CLK_60M;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK_60M) begin
        if (check_en) begin
            chk("dir",   8'(ULPI_DIR),     8'(e_dir));
            chk("oe",    8'(ULPI_DATA_OE), 8'(e_oe));
            chk("nxt",   8'(ULPI_NXT),     8'(e_nxt));
            chk("data",  ULPI_DATA_O,      e_dat);
            chk("pulse", 8'(REG_WR_PULSE), 8'(e_pulse));
            chk("func",  FUNC_CTRL,        e_func);
        end
    end

    function automatic logic [7:0] cur_rxcmd();
        return {4'b0000, VBUS_STATE, LINESTATE};
    endfunction

    function automatic int grp(input int a);
        if (a >= 4 && a <= 12) return (a - 4) / 3;
        if (a >= 22 && a <= 24) return 3;
        return -1;
    endfunction

    function automatic logic [7:0] model_rd(input int a);
        int g;
        g = grp(a);
        if (a < 2) return 8'(VID >> (8 * a));
        if (a < 4) return 8'(PID >> (8 * (a - 2)));
        if (g >= 0) return m_reg[g];
        return 8'h00;
    endfunction

    task automatic model_commit(input int a, input logic [7:0] d);
        int g;
        int op;
        g = grp(a);
        if (g >= 0) begin
            op = (g == 3) ? (a - 22) : ((a - 4) % 3);
            if (op == 0)      m_reg[g] = d;
            else if (op == 1) m_reg[g] = m_reg[g] | d;
            else              m_reg[g] = m_reg[g] & ~d;
        end
    endtask

    task automatic model_reset();
        m_reg[0] = 8'h41;
        m_reg[1] = 8'h00;
        m_reg[2] = 8'h06;
        m_reg[3] = 8'h00;
        m_last   = 8'h00;
    endtask

    // Drive one cycle of link inputs and state what the PHY must show during it.
    task automatic tick(input logic [7:0] d, input logic stp, input logic dir, input logic oe,
                        input logic nxt, input logic [7:0] dat, input logic pulse);
        ULPI_DATA_I = d;
        ULPI_STP    = stp;
        e_dir       = dir;
        e_oe        = oe;
        e_nxt       = nxt;
        e_dat       = dat;
        e_pulse     = pulse;
        e_func      = m_reg[0];
        @(posedge CLK_60M);
        #1;
    endtask

    task automatic quiet(input logic [7:0] d, input logic stp);
        tick(d, stp, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            quiet(8'h00, 1'b0);
            if (cur_rxcmd() != m_last) begin
                tick(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
                tick(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, cur_rxcmd(), 1'b0);
                m_last = cur_rxcmd();
            end
        end
    endtask

    task automatic startup_seq(input logic [7:0] lit);
        tick(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("startup_rxcmd", ULPI_DATA_O, lit);
        repeat (STARTUP_CYC) tick(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, cur_rxcmd(), 1'b0);
    endtask

    // mode 0: normal write, 1: STP in first data cycle, 2: no STP until timeout
    task automatic reg_write(input logic [5:0] a, input logic [7:0] d, input int mode);
        quiet({2'b10, a}, 1'b0);
        tick({2'b10, a}, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        if (mode == 0) begin
            quiet(d, 1'b0);
            quiet(d, 1'b1);
            model_commit(int'(a), d);
            tick(8'h40, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            m_reg[0][5] = 1'b0;
        end else begin
            if (mode == 1) begin
                quiet(d, 1'b1);
            end else begin
                repeat (WR_TIMEOUT) quiet(d, 1'b0);
                quiet(8'h5A, 1'b1);
            end
            quiet(8'h40, 1'b0);
        end
    endtask

    task automatic reg_read(input logic [5:0] a, input int lit);
        quiet({2'b11, a}, 1'b0);
        tick(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        tick(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        if (lit >= 0) chk("read_literal", ULPI_DATA_O, lit[7:0]);
        tick(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, model_rd(int'(a)), 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        NRST_A_USB  = 1'b0;
        ULPI_RESETN = 1'b1;
        ULPI_DATA_I = 8'h00;
        ULPI_STP    = 1'b0;
        LINESTATE   = 2'b01;
        VBUS_STATE  = 2'b11;
        model_reset();
        check_en    = 1'b1;

        repeat (3) tick(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        NRST_A_USB = 1'b1;
        startup_seq(8'h0D);
        idle(3);

        reg_write(6'h16, 8'hA5, 0);
        reg_read(6'h16, 8'hA5);
        idle(1);

        reg_write(6'h05, 8'h04, 0);
        chk("func_after_set", FUNC_CTRL, 8'h45);
        reg_write(6'h06, 8'h01, 0);
        chk("func_after_clear", FUNC_CTRL, 8'h44);

        reg_read(6'h01, 8'h04);
        reg_read(6'h02, 8'h06);
        reg_read(6'h03, 8'h00);

        reg_write(6'h0B, 8'h01, 0);
        reg_read(6'h0C, 8'h07);
        reg_write(6'h08, 8'h0F, 0);
        reg_write(6'h09, 8'h05, 0);
        reg_read(6'h07, 8'h0A);

        reg_write(6'h00, 8'hFF, 0);
        reg_read(6'h00, 8'h24);
        reg_write(6'h20, 8'h77, 0);
        reg_read(6'h20, 8'h00);

        reg_write(6'h04, 8'h61, 0);
        chk("func_self_clear", FUNC_CTRL, 8'h41);

        reg_write(6'h16, 8'h11, 1);
        reg_write(6'h16, 8'h9E, 2);
        reg_read(6'h16, 8'hA5);
        idle(2);

        // Line state changes on the very cycle a read TXCMD is decoded.
        LINESTATE = 2'b10;
        reg_read(6'h00, 8'h24);
        quiet(8'h00, 1'b0);
        tick(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("collision_rxcmd", ULPI_DATA_O, 8'h0E);
        tick(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, cur_rxcmd(), 1'b0);
        m_last = cur_rxcmd();
        idle(2);

        quiet(8'h96, 1'b0);
        tick(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        quiet(8'h3C, 1'b0);
        ULPI_RESETN = 1'b0;
        quiet(8'h3C, 1'b0);
        ULPI_RESETN = 1'b1;
        model_reset();
        startup_seq(8'h0E);
        idle(3);
        chk("func_after_abort", FUNC_CTRL, 8'h41);
        reg_read(6'h16, 8'h00);
        reg_read(6'h0A, 8'h06);
        idle(2);

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
